// File: rtl/pcss_link_tx.sv
// 64-bit AXI-stream to 16-bit chip-link transmitter with per-flit parity,
// one-cycle error feedback and bounded retransmission.
module pcss_link_tx #(
   parameter int DATA_WIDTH = 64,
   parameter int FLIT_WIDTH = 16,
   parameter int MAX_RETRY  = 3,
   parameter int PAR_ODD    = 0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [FLIT_WIDTH-1:0] send_data_out,
   output logic                  send_data_valid,
   output logic                  send_data_par,
   input  logic                  send_data_ready,
   input  logic                  send_data_err,
   input  logic                  clr_fail,
   output logic                  link_fail,
   output logic [CNT_W-1:0]      retry_total,
   output logic                  busy
);

   localparam int RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ERR} state_t;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   word_reg, word_next;
   logic [1:0]              idx_reg, idx_next;
   logic [RTRY_W-1:0]       rtry_reg, rtry_next;
   logic                    link_fail_reg, link_fail_next;
   logic [CNT_W-1:0]        retry_total_reg, retry_total_next;
   logic                    set_fail;

   logic [FLIT_WIDTH-1:0]   flits [4];
   logic [FLIT_WIDTH-1:0]   flit_cur;
   logic                    par_cur;

   // Flit 0 is the most significant slice of the word.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_flit
         assign flits[gi] = word_reg[DATA_WIDTH-1-gi*FLIT_WIDTH -: FLIT_WIDTH];
      end
   endgenerate

   assign flit_cur = flits[idx_reg];
   assign par_cur  = (PAR_ODD != 0) ? ~(^flit_cur) : ^flit_cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         word_reg        <= '0;
         idx_reg         <= '0;
         rtry_reg        <= '0;
         link_fail_reg   <= 1'b0;
         retry_total_reg <= '0;
      end else begin
         state_reg       <= state_next;
         word_reg        <= word_next;
         idx_reg         <= idx_next;
         rtry_reg        <= rtry_next;
         link_fail_reg   <= link_fail_next;
         retry_total_reg <= retry_total_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      word_next        = word_reg;
      idx_next         = idx_reg;
      rtry_next        = rtry_reg;
      retry_total_next = retry_total_reg;
      set_fail         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (s_axis_tvalid) begin
               word_next  = s_axis_tdata;
               idx_next   = '0;
               rtry_next  = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (send_data_ready) state_next = WAIT_ERR;
         end
         WAIT_ERR: begin
            if (send_data_err) begin
               if (rtry_reg < RTRY_W'(MAX_RETRY)) begin
                  rtry_next  = rtry_reg + 1'b1;
                  if (retry_total_reg != {CNT_W{1'b1}})
                     retry_total_next = retry_total_reg + 1'b1;
                  state_next = SEND;
               end else begin
                  // Flit gave up: the rest of the word is dropped.
                  set_fail   = 1'b1;
                  state_next = IDLE;
               end
            end else if (idx_reg == 2'd3) begin
               state_next = IDLE;
            end else begin
               idx_next   = idx_reg + 1'b1;
               rtry_next  = '0;
               state_next = SEND;
            end
         end
         default: state_next = IDLE;
      endcase
      link_fail_next = set_fail ? 1'b1 : (clr_fail ? 1'b0 : link_fail_reg);
   end

   assign s_axis_tready   = (state_reg == IDLE);
   assign send_data_valid = (state_reg == SEND);
   assign send_data_out   = send_data_valid ? flit_cur : '0;
   assign send_data_par   = send_data_valid & par_cur;
   assign link_fail       = link_fail_reg;
   assign retry_total     = retry_total_reg;
   assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_pcss_link_tx.sv
// Directed bench for pcss_link_tx: even and odd parity instances, retry,
// retry exhaustion, back-pressure, stray error reports and mid-word reset.
module tb_pcss_link_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] tdata0, tdata1;
   logic        tvalid0, tvalid1;
   logic        tready0, tready1;
   logic [15:0] out0, out1;
   logic        valid0, valid1, par0, par1;
   logic        ready, err, clr_fail;
   logic        fail0, fail1, busy0, busy1;
   logic [15:0] rtot0, rtot1;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pcss_link_tx #(.PAR_ODD(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0), .s_axis_tready(tready0),
      .send_data_out(out0), .send_data_valid(valid0), .send_data_par(par0),
      .send_data_ready(ready), .send_data_err(err),
      .clr_fail(clr_fail), .link_fail(fail0), .retry_total(rtot0), .busy(busy0)
   );

   pcss_link_tx #(.PAR_ODD(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
      .send_data_out(out1), .send_data_valid(valid1), .send_data_par(par1),
      .send_data_ready(ready), .send_data_err(err),
      .clr_fail(clr_fail), .link_fail(fail1), .retry_total(rtot1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Offer a word to u0 for one cycle; returns at the first SEND cycle.
   task automatic start0(input logic [63:0] w);
      tdata0  = w;
      tvalid0 = 1'b1;
      tick();
      tvalid0 = 1'b0;
   endtask

   task automatic exp_flit(input string tag, input logic [15:0] f, input logic p);
      chk({tag, " valid"}, valid0, 1'b1);
      chk({tag, " data"}, out0, f);
      chk({tag, " par"}, par0, p);
      chk({tag, " tready"}, tready0, 1'b0);
      tick();
   endtask

   task automatic exp_gap(input string tag, input logic e);
      chk({tag, " gap valid"}, valid0, 1'b0);
      chk({tag, " gap data"}, out0, 16'h0);
      chk({tag, " gap busy"}, busy0, 1'b1);
      err = e;
      tick();
      err = 1'b0;
   endtask

   logic [15:0] odd_flits [4];
   logic        odd_pars  [4];

   initial begin
      rst_n = 1'b0; tdata0 = '0; tdata1 = '0; tvalid0 = 0; tvalid1 = 0;
      ready = 1'b1; err = 1'b0; clr_fail = 1'b0;
      odd_flits = '{16'h0001, 16'h0003, 16'h0007, 16'hFFFF};
      odd_pars  = '{1'b0, 1'b1, 1'b0, 1'b1};
      repeat (3) @(negedge clk);

      chk("rst tready", tready0, 1'b1);
      chk("rst valid", valid0, 1'b0);
      chk("rst data", out0, 16'h0);
      chk("rst par", par0, 1'b0);
      chk("rst link_fail", fail0, 1'b0);
      chk("rst retry_total", rtot0, 16'h0);
      chk("rst busy", busy0, 1'b0);
      rst_n = 1'b1;
      tick();

      // Error-free word: flits on cycles 1,3,5,7, idle again at cycle 9.
      start0(64'h0123_4567_89AB_CDEF);
      exp_flit("w1 f0", 16'h0123, 1'b0); exp_gap("w1 f0", 1'b0);
      exp_flit("w1 f1", 16'h4567, 1'b0); exp_gap("w1 f1", 1'b0);
      exp_flit("w1 f2", 16'h89AB, 1'b0); exp_gap("w1 f2", 1'b0);
      exp_flit("w1 f3", 16'hCDEF, 1'b0); exp_gap("w1 f3", 1'b0);
      chk("w1 tready", tready0, 1'b1);
      chk("w1 busy", busy0, 1'b0);
      chk("w1 retry_total", rtot0, 16'h0);

      // Odd parity instance.
      tdata1 = 64'h0001_0003_0007_FFFF;
      tvalid1 = 1'b1;
      tick();
      tvalid1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("odd f%0d valid", i), valid1, 1'b1);
         chk($sformatf("odd f%0d data", i), out1, odd_flits[i]);
         chk($sformatf("odd f%0d par", i), par1, odd_pars[i]);
         tick();
         chk($sformatf("odd f%0d gap", i), valid1, 1'b0);
         tick();
      end
      chk("odd tready", tready1, 1'b1);

      // Exhaustion: flit 0 sent 4 times; clr_fail in the failing cycle loses.
      start0(64'hA5A5_1234_5678_9ABC);
      for (int i = 0; i < 3; i++) begin
         exp_flit($sformatf("ex try%0d", i), 16'hA5A5, 1'b0);
         exp_gap($sformatf("ex try%0d", i), 1'b1);
      end
      exp_flit("ex try3", 16'hA5A5, 1'b0);
      clr_fail = 1'b1;
      exp_gap("ex try3", 1'b1);
      clr_fail = 1'b0;
      chk("ex link_fail", fail0, 1'b1);
      chk("ex tready", tready0, 1'b1);
      chk("ex valid", valid0, 1'b0);
      chk("ex retry_total", rtot0, 16'd3);

      // Next word still goes out while link_fail is set.
      start0(64'h0123_4567_89AB_CDEF);
      exp_flit("w2 f0", 16'h0123, 1'b0); exp_gap("w2 f0", 1'b0);
      exp_flit("w2 f1", 16'h4567, 1'b0); exp_gap("w2 f1", 1'b0);
      exp_flit("w2 f2", 16'h89AB, 1'b0); exp_gap("w2 f2", 1'b0);
      exp_flit("w2 f3", 16'hCDEF, 1'b0); exp_gap("w2 f3", 1'b0);
      chk("w2 link_fail held", fail0, 1'b1);
      clr_fail = 1'b1;
      tick();
      clr_fail = 1'b0;
      chk("clr link_fail", fail0, 1'b0);

      // Single retry on the second flit; retry_total accumulates to 4.
      start0(64'h0123_4567_89AB_CDEF);
      exp_flit("rt f0", 16'h0123, 1'b0); exp_gap("rt f0", 1'b0);
      exp_flit("rt f1", 16'h4567, 1'b0); exp_gap("rt f1", 1'b1);
      exp_flit("rt f1b", 16'h4567, 1'b0); exp_gap("rt f1b", 1'b0);
      exp_flit("rt f2", 16'h89AB, 1'b0); exp_gap("rt f2", 1'b0);
      exp_flit("rt f3", 16'hCDEF, 1'b0); exp_gap("rt f3", 1'b0);
      chk("rt retry_total", rtot0, 16'd4);
      chk("rt link_fail", fail0, 1'b0);
      chk("rt tready", tready0, 1'b1);

      // Back-pressure on flit 2 with a stray err during SEND.
      start0(64'h0123_4567_89AB_CDEF);
      exp_flit("bp f0", 16'h0123, 1'b0); exp_gap("bp f0", 1'b0);
      exp_flit("bp f1", 16'h4567, 1'b0); exp_gap("bp f1", 1'b0);
      ready = 1'b0;
      err   = 1'b1;
      for (int i = 0; i < 5; i++) exp_flit($sformatf("bp hold%0d", i), 16'h89AB, 1'b0);
      err   = 1'b0;
      ready = 1'b1;
      exp_flit("bp f2", 16'h89AB, 1'b0); exp_gap("bp f2", 1'b0);
      exp_flit("bp f3", 16'hCDEF, 1'b0); exp_gap("bp f3", 1'b0);
      chk("bp retry_total", rtot0, 16'd4);
      chk("bp tready", tready0, 1'b1);

      // Reset while the second flit is pending.
      start0(64'h0123_4567_89AB_CDEF);
      exp_flit("rm f0", 16'h0123, 1'b0); exp_gap("rm f0", 1'b0);
      chk("rm pre valid", valid0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rm valid", valid0, 1'b0);
      chk("rm tready", tready0, 1'b1);
      chk("rm busy", busy0, 1'b0);
      chk("rm data", out0, 16'h0);
      chk("rm retry_total", rtot0, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rm idle valid", valid0, 1'b0);
      start0(64'hFEDC_BA98_7654_3210);
      exp_flit("nw f0", 16'hFEDC, 1'b0); exp_gap("nw f0", 1'b0);
      exp_flit("nw f1", 16'hBA98, 1'b0); exp_gap("nw f1", 1'b0);
      exp_flit("nw f2", 16'h7654, 1'b0); exp_gap("nw f2", 1'b0);
      exp_flit("nw f3", 16'h3210, 1'b0); exp_gap("nw f3", 1'b0);
      chk("nw tready", tready0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
